picomips_core: RTL and testbench

- Parametrised successor to the picoMips datapath: a multi-cycle, accumulator-based core generalised in data width, register count and program-address width.
- Adds behaviour the fixed 8-bit design lacks: conditional and unconditional branches, a valid/ready input handshake, a strobed output, a saturating fractional multiply and a sticky halt.
- Instructions are fetched over an external synchronous program-memory port, so the core stays memory-agnostic.
- Sits between the program memory and the board I/O (switches/LEDs) in the top level.

---
 rtl/picomips_pkg.sv | 37 +++
 rtl/picomips_if.sv | 21 ++
 rtl/picomips_regfile.sv | 25 ++
 rtl/picomips_core.sv | 109 ++++++++++
 tb/tb_picomips_core.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/picomips_pkg.sv
// picomips_pkg: opcodes, FSM states and instruction field helpers for the picoMips core
package picomips_pkg;

   localparam int OPC_W = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP  = 4'd0,
      OP_LDI  = 4'd1,
      OP_LDR  = 4'd2,
      OP_STR  = 4'd3,
      OP_ADDI = 4'd4,
      OP_ADDR = 4'd5,
      OP_MULI = 4'd6,
      OP_MULR = 4'd7,
      OP_IN   = 4'd8,
      OP_OUT  = 4'd9,
      OP_BZ   = 4'd10,
      OP_JMP  = 4'd11,
      OP_HALT = 4'd12
   } opcode_e;

   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

   // Instructions are passed zero-extended to 64 bits so one helper serves every width.
   function automatic logic [OPC_W-1:0] f_opc(input logic [63:0] ins, input int reg_aw, input int data_w);
      return ins[reg_aw+data_w +: OPC_W];
   endfunction

   function automatic logic [63:0] f_reg(input logic [63:0] ins, input int reg_aw, input int data_w);
      return (ins >> data_w) & ((64'd1 << reg_aw) - 64'd1);
   endfunction

   function automatic logic [63:0] f_imm(input logic [63:0] ins, input int data_w);
      return ins & ((64'd1 << data_w) - 64'd1);
   endfunction

endpackage

// File: rtl/picomips_if.sv
// picomips_if: program-memory port, input handshake and output strobe of the core
interface picomips_if
   import picomips_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int PC_W     = 5
);
   localparam int INSTR_W = OPC_W + $clog2(NUM_REGS) + DATA_W;

   logic [PC_W-1:0]    InstrAddr;
   logic [INSTR_W-1:0] Instr;
   logic [DATA_W-1:0]  InData;
   logic               InValid;
   logic               InReady;
   logic [DATA_W-1:0]  OutData;
   logic               OutValid;

   modport master (output InstrAddr, InReady, OutData, OutValid, input Instr, InData, InValid);
   modport slave  (input InstrAddr, InReady, OutData, OutValid, output Instr, InData, InValid);
endinterface

// File: rtl/picomips_regfile.sv
// picomips_regfile: general registers, one write port and one combinational read port
module picomips_regfile #(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [$clog2(NUM_REGS)-1:0] addr,
   input  logic                        we,
   input  logic [DATA_W-1:0]           wdata,
   output logic [DATA_W-1:0]           rdata
);
   logic [DATA_W-1:0] regs [NUM_REGS];

   // storage: cleared by reset, written by STR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[addr] <= wdata;
      end
   end

   assign rdata = regs[addr];
endmodule

// File: rtl/picomips_core.sv
// picomips_core: two-cycle accumulator core with branches, IN handshake, OUT strobe and halt
module picomips_core
   import picomips_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int PC_W     = 5
) (
   input  logic              Clock,
   input  logic              nReset,
   picomips_if.master        bus,
   output logic [DATA_W-1:0] Acc,
   output logic              Halted
);
   localparam int REG_AW = $clog2(NUM_REGS);
   localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   state_e                   state, state_n;
   logic [PC_W-1:0]          pc, pc_n;
   logic signed [DATA_W-1:0] acc, acc_n, imm, rd, opnd, mul_res;
   logic signed [2*DATA_W-2:0] prod;
   logic [DATA_W-1:0]        out_data, out_n;
   logic                     out_valid, ov_n, we;
   logic [OPC_W-1:0]         opc;
   logic [REG_AW-1:0]        r;

   assign opc = f_opc(64'(bus.Instr), REG_AW, DATA_W);
   assign r   = REG_AW'(f_reg(64'(bus.Instr), REG_AW, DATA_W));
   assign imm = DATA_W'(f_imm(64'(bus.Instr), DATA_W));

   // The product only overflows 2*DATA_W-1 bits for MIN*MIN, which is saturated anyway.
   assign opnd    = (opc == OP_MULI) ? imm : rd;
   assign prod    = acc * opnd;
   assign mul_res = (acc == S_MIN && opnd == S_MIN) ? S_MAX : DATA_W'(prod >>> (DATA_W-1));

   picomips_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_regs (
      .clk  (Clock),
      .rst_n(nReset),
      .addr (r),
      .we   (we),
      .wdata(acc),
      .rdata(rd)
   );

   assign bus.InstrAddr = pc;
   assign bus.InReady   = (state == EXEC) && (opc == OP_IN);
   assign bus.OutData   = out_data;
   assign bus.OutValid  = out_valid;
   assign Acc           = acc;
   assign Halted        = (state == HALT);

   // architectural state register
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state     <= FETCH;
         pc        <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         acc       <= acc_n;
         out_data  <= out_n;
         out_valid <= ov_n;
      end
   end

   // next state: fetch one cycle, execute the next; IN waits in EXEC for InValid
   always_comb begin
      state_n = state;
      pc_n    = pc;
      acc_n   = acc;
      out_n   = out_data;
      ov_n    = 1'b0;
      we      = 1'b0;
      if (state == FETCH) begin
         state_n = EXEC;
      end else if (state == EXEC) begin
         state_n = FETCH;
         pc_n    = pc + PC_W'(1);
         case (opc)
            OP_LDI:           acc_n = imm;
            OP_LDR:           acc_n = rd;
            OP_STR:           we = 1'b1;
            OP_ADDI:          acc_n = acc + imm;
            OP_ADDR:          acc_n = acc + rd;
            OP_MULI, OP_MULR: acc_n = mul_res;
            OP_IN: begin
               acc_n   = bus.InValid ? bus.InData : acc;
               state_n = bus.InValid ? FETCH : EXEC;
               pc_n    = bus.InValid ? pc + PC_W'(1) : pc;
            end
            OP_OUT: begin
               out_n = acc;
               ov_n  = 1'b1;
            end
            OP_BZ:            pc_n = (acc == '0) ? imm[PC_W-1:0] : pc + PC_W'(1);
            OP_JMP:           pc_n = imm[PC_W-1:0];
            OP_HALT: begin
               state_n = HALT;
               pc_n    = pc;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_picomips_core.sv
// tb_picomips_core: directed checks of reset, arithmetic, multiply, handshake, branch and halt
module tb_picomips_core;
   import picomips_pkg::*;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic [7:0] acc;
   logic       halted;
   logic [13:0] mem [32];
   logic [13:0] instr_q = '0;
   int checks = 0;
   int failures = 0;

   picomips_if bus ();

   picomips_core dut (
      .Clock (clk),
      .nReset(nreset),
      .bus   (bus),
      .Acc   (acc),
      .Halted(halted)
   );

   always #5 clk = ~clk;

   // synchronous program memory: data valid one cycle after the address
   always_ff @(posedge clk) instr_q <= mem[bus.InstrAddr];
   assign bus.Instr = instr_q;

   function automatic logic [13:0] enc(input logic [3:0] op, input logic [1:0] r, input logic [7:0] imm);
      return {op, r, imm};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = '0;
   endtask

   task automatic start();
      nreset = 1'b0;
      cyc(3);
      nreset = 1'b1;
   endtask

   initial begin
      bus.InValid = 1'b0;
      bus.InData  = '0;
      clear_mem();
      mem[0] = enc(OP_LDI, 2'd0, 8'd127);
      mem[1] = enc(OP_ADDI, 2'd0, 8'd1);
      mem[2] = enc(OP_OUT, 2'd0, 8'd0);
      mem[3] = enc(OP_JMP, 2'd0, 8'd3);
      cyc(3);
      chk("rst_acc", 32'(acc), 32'h0);
      chk("rst_addr", 32'(bus.InstrAddr), 32'h0);
      chk("rst_outdata", 32'(bus.OutData), 32'h0);
      chk("rst_outvalid", 32'(bus.OutValid), 32'h0);
      chk("rst_inready", 32'(bus.InReady), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      nreset = 1'b1;
      cyc(5);
      chk("out_before", 32'(bus.OutValid), 32'h0);
      cyc(1);
      chk("out_strobe", 32'(bus.OutValid), 32'h1);
      chk("out_data", 32'(bus.OutData), 32'h80);
      chk("out_acc", 32'(acc), 32'h80);
      cyc(1);
      chk("out_after", 32'(bus.OutValid), 32'h0);
      cyc(1);
      chk("out_after2", 32'(bus.OutValid), 32'h0);
      nreset = 1'b0;
      #1;
      chk("pulse_addr", 32'(bus.InstrAddr), 32'h0);
      chk("pulse_acc", 32'(acc), 32'h0);
      chk("pulse_outdata", 32'(bus.OutData), 32'h0);

      clear_mem();
      mem[0]  = enc(OP_LDI, 2'd0, 8'd64);
      mem[1]  = enc(OP_MULI, 2'd0, 8'd64);
      mem[2]  = enc(OP_LDI, 2'd0, 8'h80);
      mem[3]  = enc(OP_MULI, 2'd0, 8'h80);
      mem[4]  = enc(OP_LDI, 2'd0, 8'hC0);
      mem[5]  = enc(OP_STR, 2'd3, 8'd0);
      mem[6]  = enc(OP_LDI, 2'd0, 8'd64);
      mem[7]  = enc(OP_MULR, 2'd3, 8'd0);
      mem[8]  = enc(OP_LDI, 2'd0, 8'd9);
      mem[9]  = enc(OP_STR, 2'd1, 8'd0);
      mem[10] = enc(OP_LDR, 2'd1, 8'd0);
      mem[11] = enc(OP_LDR, 2'd3, 8'd0);
      mem[12] = enc(OP_ADDR, 2'd1, 8'd0);
      mem[13] = enc(OP_HALT, 2'd0, 8'd0);
      start();
      chk("fetch_addr0", 32'(bus.InstrAddr), 32'h0);
      cyc(4);
      chk("muli_64x64", 32'(acc), 32'h20);
      cyc(4);
      chk("muli_sat", 32'(acc), 32'h7F);
      cyc(8);
      chk("mulr_neg", 32'(acc), 32'hE0);
      cyc(6);
      chk("str_ldr", 32'(acc), 32'h09);
      cyc(2);
      chk("ldr_r3", 32'(acc), 32'hC0);
      cyc(2);
      chk("addr_r1", 32'(acc), 32'hC9);

      clear_mem();
      mem[0] = enc(OP_IN, 2'd0, 8'd0);
      mem[1] = enc(OP_ADDI, 2'd0, 8'd1);
      mem[2] = enc(OP_HALT, 2'd0, 8'd0);
      start();
      cyc(2);
      chk("in_ready_pre", 32'(bus.InReady), 32'h1);
      nreset = 1'b0;
      #1;
      chk("in_abandon", 32'(bus.InReady), 32'h0);
      start();
      for (int i = 1; i <= 6; i++) begin
         cyc(1);
         chk("in_wait_ready", 32'(bus.InReady), 32'h1);
         chk("in_wait_addr", 32'(bus.InstrAddr), 32'h0);
         chk("in_wait_acc", 32'(acc), 32'h0);
         if (i == 6) begin
            bus.InValid = 1'b1;
            bus.InData  = 8'h25;
         end
      end
      cyc(1);
      chk("in_acc", 32'(acc), 32'h25);
      chk("in_addr", 32'(bus.InstrAddr), 32'h1);
      chk("in_ready_drop", 32'(bus.InReady), 32'h0);
      bus.InData = 8'h55;
      cyc(1);
      chk("in_ignored", 32'(bus.InReady), 32'h0);
      cyc(1);
      chk("in_then_addi", 32'(acc), 32'h26);
      bus.InValid = 1'b0;

      clear_mem();
      mem[0]  = enc(OP_LDI, 2'd0, 8'd0);
      mem[1]  = enc(OP_BZ, 2'd0, 8'd3);
      mem[2]  = enc(OP_HALT, 2'd0, 8'd0);
      mem[3]  = enc(OP_LDI, 2'd0, 8'd1);
      mem[4]  = enc(OP_BZ, 2'd0, 8'd7);
      mem[5]  = enc(OP_JMP, 2'd0, 8'd31);
      mem[7]  = enc(OP_HALT, 2'd0, 8'd0);
      mem[31] = enc(OP_NOP, 2'd0, 8'd0);
      start();
      cyc(4);
      chk("bz_taken", 32'(bus.InstrAddr), 32'h3);
      cyc(4);
      chk("bz_not_taken", 32'(bus.InstrAddr), 32'h5);
      cyc(2);
      chk("jmp_31", 32'(bus.InstrAddr), 32'd31);
      cyc(2);
      chk("pc_wrap", 32'(bus.InstrAddr), 32'h0);

      clear_mem();
      mem[0] = enc(OP_LDI, 2'd0, 8'd5);
      mem[1] = enc(OP_OUT, 2'd0, 8'd0);
      mem[7] = enc(OP_HALT, 2'd0, 8'd0);
      mem[8] = enc(OP_LDI, 2'd0, 8'd9);
      start();
      cyc(15);
      chk("halt_before", 32'(halted), 32'h0);
      cyc(1);
      chk("halt_set", 32'(halted), 32'h1);
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("halt_hold", {28'(bus.InstrAddr), 3'(0), bus.OutValid}, {28'd7, 3'(0), 1'b0});
         chk("halt_acc", {24'(0), acc}, {24'(0), 8'd5});
         chk("halt_flag", 32'(halted), 32'h1);
      end
      nreset = 1'b0;
      #1;
      chk("halt_reset", 32'(halted), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
